// File: rtl/ram_arb_pkg.sv
// Shared types and RAM command opcodes for the ram_arbiter slice.
// RAM_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WAIT_RD = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic [1:0] addr_cmd(input logic we);
    return we ? CMD_WR_ADDR : CMD_RD_ADDR;
  endfunction

  function automatic logic [1:0] data_cmd(input logic we);
    return we ? CMD_WR_DATA : CMD_RD_DATA;
  endfunction

endpackage

// File: rtl/ram_arb_sel.sv
// Combinational one-hot winner select over the request vector.
// With RAM_ARB_RR_EN the search starts one past the pointer; otherwise lowest index wins.
module ram_arb_sel
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
`ifdef RAM_ARB_RR_EN
  input  logic [$clog2(NREQ)-1:0] ptr_i,
`endif
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o
);

`ifdef RAM_ARB_RR_EN
  localparam int PW = $clog2(NREQ);

  logic          found_s;
  logic          hit_s;
  logic [PW-1:0] idx_s;

  // rotate the search start to ptr+1 so the last winner is considered last
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s        = PW'((int'(ptr_i) + 1 + i) % NREQ);
      hit_s        = req_i[idx_s] & ~found_s;
      gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
      found_s      = found_s | hit_s;
    end
  end
`else
  logic found_s;
  logic hit_s;

  // first set bit from index 0 upward wins
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hit_s    = req_i[i] & ~found_s;
      gnt_o[i] = hit_s;
      found_s  = found_s | hit_s;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates NREQ requesters onto the single-port command-driven RAM (RAM_ARB_RR_EN
// enables round-robin). Every output, including the RAM command port, is a register.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       err,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic [DATA_WIDTH+1:0]      ram_din,
  output logic                       ram_rx_valid,
  input  logic                       ram_tx_valid,
  input  logic [DATA_WIDTH-1:0]      ram_dout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e                  state_q;
  logic [NREQ-1:0]         grant_q;
  logic                    busy_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH+1:0]   ram_din_q;
  logic                    rx_valid_q;
  logic [NREQ-1:0]         ack_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic [NREQ-1:0]         sel_gnt_s;
  logic                    sel_we_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;

`ifdef RAM_ARB_RR_EN
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]           ptr_q;
  logic [IW-1:0]           win_idx_s;

  ram_arb_sel #(.NREQ(NREQ)) u_sel (
    .ptr_i (ptr_q),
    .req_i (req),
    .gnt_o (sel_gnt_s)
  );

  // index of the one-hot winner, stored as the next search origin
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s = win_idx_s | (sel_gnt_s[i] ? IW'(i) : '0);
    end
  end
`else
  ram_arb_sel #(.NREQ(NREQ)) u_sel (
    .req_i (req),
    .gnt_o (sel_gnt_s)
  );
`endif

  // mux the winner's operands out of the flattened buses using the one-hot grant
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_we_s    = sel_we_s | (req_we[i] & sel_gnt_s[i]);
      sel_addr_s  = sel_addr_s | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{sel_gnt_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_gnt_s[i]}});
    end
  end

  // transaction FSM; each command word is loaded on entry to the state that presents it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ram_din_q  <= '0;
      rx_valid_q <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef RAM_ARB_RR_EN
      ptr_q      <= IW'(NREQ - 1);
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q    <= sel_gnt_s;
            busy_q     <= 1'b1;
            we_q       <= sel_we_s;
            addr_q     <= sel_addr_s;
            wdata_q    <= sel_wdata_s;
            ram_din_q  <= {addr_cmd(sel_we_s), {(DATA_WIDTH-ADDR_WIDTH){1'b0}}, sel_addr_s};
            rx_valid_q <= 1'b1;
`ifdef RAM_ARB_RR_EN
            ptr_q      <= win_idx_s;
`endif
            state_q    <= ADDR;
          end else begin
            rx_valid_q <= 1'b0;
          end
        end
        ADDR: begin
          ram_din_q  <= {data_cmd(we_q), we_q ? wdata_q : {DATA_WIDTH{1'b0}}};
          rx_valid_q <= 1'b1;
          state_q    <= DATA;
        end
        DATA: begin
          rx_valid_q <= 1'b0;
          cnt_q      <= '0;
          if (we_q) begin
            ack_q   <= grant_q;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            err_q   <= 1'b0;
            ack_q   <= grant_q;
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            ack_q   <= grant_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant_q    <= '0;
          busy_q     <= 1'b0;
          rx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (NREQ=2, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled on the falling edge; cycle n follows rising edge n-1.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_we, ack, grant;
  logic [15:0] req_addr, req_wdata;
  logic [7:0]  rdata, ram_dout;
  logic        err, busy, ram_rx_valid, ram_tx_valid;
  logic [9:0]  ram_din;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.NREQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .rdata        (rdata),
    .err          (err),
    .grant        (grant),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_tx_valid (ram_tx_valid),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; req_we = 2'b00; req_addr = 16'h0000; req_wdata = 16'h0000;
    ram_tx_valid = 1'b0; ram_dout = 8'h00;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ram_din, ram_rx_valid, ack, rdata, err, grant, busy} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs din=%h rxv=%b ack=%b rdata=%h err=%b grant=%b busy=%b, all must be 0",
               ram_din, ram_rx_valid, ack, rdata, err, grant, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      failures++; $display("FAIL reset_idle busy=%b grant=%b expected 0/00", busy, grant);
    end
  endtask

  task automatic test_write();
    req_we = 2'b01; req_addr = 16'h003C; req_wdata = 16'h00A5; req = 2'b01;
    @(negedge clk); // cycle 1
    checks++;
    if (ram_din !== 10'h03C || ram_rx_valid !== 1'b1 || grant !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_addr_word din=%h rxv=%b grant=%b busy=%b expected 03c/1/01/1", ram_din, ram_rx_valid, grant, busy);
    end
    req_addr = 16'h00FF; req_wdata = 16'h0000;
    @(negedge clk); // cycle 2
    checks++;
    if (ram_din !== 10'h1A5 || ram_rx_valid !== 1'b1 || ack !== 2'b00) begin
      failures++; $display("FAIL wr_data_word din=%h rxv=%b ack=%b expected 1a5/1/00", ram_din, ram_rx_valid, ack);
    end
    @(negedge clk); // cycle 3
    checks++;
    if (ack !== 2'b01 || err !== 1'b0 || ram_rx_valid !== 1'b0 || ram_din !== 10'h1A5) begin
      failures++;
      $display("FAIL wr_ack ack=%b err=%b rxv=%b din=%h expected 01/0/0/1a5", ack, err, ram_rx_valid, ram_din);
    end
    req = 2'b00;
    @(negedge clk); // cycle 4
    checks++;
    if (ack !== 2'b00 || busy !== 1'b0 || grant !== 2'b00) begin
      failures++; $display("FAIL wr_release ack=%b busy=%b grant=%b expected 00/0/00", ack, busy, grant);
    end
  endtask

  task automatic test_read();
    req_we = 2'b00; req_addr = 16'h3C00; req = 2'b10;
    @(negedge clk); // cycle 1
    checks++;
    if (ram_din !== 10'h23C || ram_rx_valid !== 1'b1 || grant !== 2'b10) begin
      failures++; $display("FAIL rd_addr_word din=%h rxv=%b grant=%b expected 23c/1/10", ram_din, ram_rx_valid, grant);
    end
    ram_tx_valid = 1'b1; ram_dout = 8'hFF; // stray strobe during ADDR/DATA must be ignored
    @(negedge clk); // cycle 2
    checks++;
    if (ram_din !== 10'h300 || ram_rx_valid !== 1'b1) begin
      failures++; $display("FAIL rd_data_word din=%h rxv=%b expected 300/1", ram_din, ram_rx_valid);
    end
    ram_tx_valid = 1'b0; req = 2'b00;
    @(negedge clk); // cycle 3
    checks++;
    if (ack !== 2'b00 || ram_rx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL rd_wait ack=%b rxv=%b busy=%b expected 00/0/1", ack, ram_rx_valid, busy);
    end
    @(negedge clk); // cycle 4: two cycles after the 0x300 word
    ram_tx_valid = 1'b1; ram_dout = 8'hA5;
    @(negedge clk); // cycle 5
    checks++;
    if (ack !== 2'b10 || rdata !== 8'hA5 || err !== 1'b0) begin
      failures++; $display("FAIL rd_ack ack=%b rdata=%h err=%b expected 10/a5/0", ack, rdata, err);
    end
    ram_tx_valid = 1'b0;
    @(negedge clk);
  endtask

  // late_hit=1 raises tx_valid on the last wait cycle, which must still count as success
  task automatic test_timeout(input bit late_hit);
    int early;
    early = 0;
    req_we = 2'b00; req_addr = 16'h0010; req = 2'b01;
    @(negedge clk); // cycle 1
    checks++;
    if (ram_din !== 10'h210) begin
      failures++; $display("FAIL to_addr_word din=%h expected 210", ram_din);
    end
    @(negedge clk); // cycle 2
    req = 2'b00;
    for (int c = 3; c <= 18; c++) begin
      @(negedge clk);
      if (ack !== 2'b00) early++;
      if (late_hit && c == 18) begin
        ram_tx_valid = 1'b1; ram_dout = 8'h5A;
      end
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL to_no_early_ack early_acks=%0d expected 0", early);
    end
    @(negedge clk); // cycle 19 = 3 + TIMEOUT_CYC
    ram_tx_valid = 1'b0;
    checks++;
    if (late_hit) begin
      if (ack !== 2'b01 || err !== 1'b0 || rdata !== 8'h5A) begin
        failures++; $display("FAIL to_edge_hit ack=%b err=%b rdata=%h expected 01/0/5a", ack, err, rdata);
      end
    end else begin
      if (ack !== 2'b01 || err !== 1'b1 || rdata !== 8'h00) begin
        failures++; $display("FAIL to_expire ack=%b err=%b rdata=%h expected 01/1/00", ack, err, rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_ack;
    int n;
    req_we = 2'b11; req_addr = 16'h2211; req_wdata = 16'h4433; req = 2'b11;
    for (int t = 0; t < 4; t++) begin
`ifdef RAM_ARB_RR_EN
      // requester 0 was granted last, so the rotation resumes at requester 1
      exp_ack = (t % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_ack = 2'b01;
`endif
      n = 0;
      while (ack === 2'b00 && n < 12) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (ack !== exp_ack) begin
        failures++; $display("FAIL arb_grant_%0d ack=%b expected %b (cycles waited %0d)", t, ack, exp_ack, n);
      end
      if (t == 3) req = 2'b00;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_we = 2'b01; req_addr = 16'h003C; req_wdata = 16'h0081; req = 2'b01;
    @(negedge clk); // cycle 1
    @(negedge clk); // cycle 2 (DATA)
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_rx_valid !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 || ack !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_abort rxv=%b busy=%b grant=%b ack=%b expected 0/0/00/00", ram_rx_valid, busy, grant, ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); // fresh cycle 1
    checks++;
    if (ram_din !== 10'h03C || ram_rx_valid !== 1'b1 || grant !== 2'b01 || ack !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_regrant din=%h rxv=%b grant=%b ack=%b expected 03c/1/01/00", ram_din, ram_rx_valid, grant, ack);
    end
    req = 2'b00;
    @(negedge clk); // cycle 2
    checks++;
    if (ram_din !== 10'h181) begin
      failures++; $display("FAIL rst_mid_data din=%h expected 181", ram_din);
    end
    @(negedge clk); // cycle 3
    checks++;
    if (ack !== 2'b01 || err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_ack ack=%b err=%b expected 01/0", ack, err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
